// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the MEM-stage SRAM bridge.
//   state_e  - controller FSM states (IDLE, LOW, HIGH, DONE)
//   HALF_W   - SRAM data width (one half-word)
//   WORD_W   - CPU data width (one word)
//   WAIT_W   - width of the wait-state counter (covers WAIT_CYCLES 0..7)
package sram_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WAIT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: wait-state counter shared by the LOW and HIGH phases.
// Ports:
//   clock     in  rising-edge clock
//   reset     in  asynchronous active-low reset
//   load      in  reload the counter with load_val (phase entry)
//   dec       in  decrement by one while non-zero
//   load_val  in  reload value (WAIT_CYCLES)
//   zero      out counter currently reads zero (last cycle of a phase)
module sram_wait_counter
  import sram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              zero
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sram_controller.sv
// sram_controller: multi-cycle bridge between the MEM stage and a 16-bit
// asynchronous SRAM. A 32-bit load/store is split into a low-half and a
// high-half SRAM access, each held for WAIT_CYCLES+1 cycles. ready=0 freezes
// the pipeline while an access is in flight.
// Optional build macro SRAM_RANGE_CHECK_EN: out-of-range requests skip the
// SRAM entirely, return read_data=0 and raise range_err in DONE.
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   rd_en, wr_en          MEM-stage load/store request (store wins if both)
//   address, write_data   CPU byte address (bits[1:0] ignored) and store data
//   read_data, ready      load result (valid in DONE) and not-freeze flag
//   sram_addr             half-word address to the SRAM
//   sram_dq_out/_in/_oe   pad data out, pad data in, pad driver enable
//   sram_we_n, sram_oe_n  active-low write strobe and output enable
//   range_err             (SRAM_RANGE_CHECK_EN only) out-of-range request
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [WORD_W-1:0]  address,
  input  logic [WORD_W-1:0]  write_data,
  output logic [WORD_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HALF_W-1:0]  sram_dq_out,
  input  logic [HALF_W-1:0]  sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
`ifdef SRAM_RANGE_CHECK_EN
  output logic               sram_oe_n,
  output logic               range_err
`else
  output logic               sram_oe_n
`endif
);

  localparam int unsigned WORD_AW = SRAM_AW - 1;

  state_e               state_q, state_d;
  logic [WORD_AW-1:0]   word_q, word_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
  logic                 is_wr_q, is_wr_d;
  logic [WORD_W-1:0]    rdata_q, rdata_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [HALF_W-1:0]    dq_out_q, dq_out_d;
  logic                 dq_oe_q, dq_oe_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 range_err_q, range_err_d;

  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;

  logic [WORD_W-1:0]    req_off;
  logic [WORD_AW-1:0]   req_word;
  logic                 req_skip;
  logic                 unused_bits;

  // Offset from the SRAM window; the word index wraps modulo the SRAM size.
  assign req_off  = address - WORD_W'(ADDR_BASE);
  assign req_word = req_off[SRAM_AW:2];

`ifdef SRAM_RANGE_CHECK_EN
  // Below the base or beyond the last SRAM word: bypass the SRAM.
  assign req_skip    = (address < WORD_W'(ADDR_BASE)) ||
                       ((req_off[WORD_W-1:2] >> WORD_AW) != '0);
  assign unused_bits = ^req_off[1:0];
`else
  assign req_skip    = 1'b0;
  assign unused_bits = ^{req_off[WORD_W-1:SRAM_AW+1], req_off[1:0]};
`endif

  sram_wait_counter u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_W'(WAIT_CYCLES)),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    range_err_d = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    ready       = 1'b0;

    // All SRAM outputs are registered, so each branch computes the pin
    // values for the cycle that follows the edge.
    case (state_q)
      ST_IDLE: begin
        ready = ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          is_wr_d = wr_en;
          word_d  = req_word;
          wdata_d = write_data;
          if (req_skip) begin
            state_d     = ST_DONE;
            rdata_d     = '0;
            range_err_d = 1'b1;
          end else begin
            state_d  = ST_LOW;
            cnt_load = 1'b1;
            addr_d   = {req_word, 1'b0};
            if (wr_en) begin
              dq_out_d = write_data[HALF_W-1:0];
            end
            dq_oe_d = wr_en;
            we_n_d  = ~wr_en;
            oe_n_d  = wr_en;
          end
        end
      end

      ST_LOW: begin
        dq_oe_d = is_wr_q;
        we_n_d  = ~is_wr_q;
        oe_n_d  = is_wr_q;
        if (cnt_zero) begin
          if (!is_wr_q) begin
            rdata_d[HALF_W-1:0] = sram_dq_in;
          end
          state_d  = ST_HIGH;
          cnt_load = 1'b1;
          addr_d   = {word_q, 1'b1};
          if (is_wr_q) begin
            dq_out_d = wdata_q[WORD_W-1:HALF_W];
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_HIGH: begin
        if (cnt_zero) begin
          // Strobes fall back to their inactive defaults for DONE.
          if (!is_wr_q) begin
            rdata_d[WORD_W-1:HALF_W] = sram_dq_in;
          end
          state_d = ST_DONE;
        end else begin
          dq_oe_d = is_wr_q;
          we_n_d  = ~is_wr_q;
          oe_n_d  = is_wr_q;
          cnt_dec = 1'b1;
        end
      end

      default: begin
        // DONE: requests seen here are re-examined in IDLE next cycle.
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      range_err_q <= range_err_d;
    end
  end

  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

`ifdef SRAM_RANGE_CHECK_EN
  assign range_err = range_err_q;
`else
  logic unused_range_err;
  assign unused_range_err = range_err_q ^ unused_bits;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed bench for sram_controller at default
// parameters (ADDR_BASE=1024, WAIT_CYCLES=2, SRAM_AW=18), with a small
// behavioural SRAM and a queue of expected read_data values.
module tb_sram_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
`ifdef SRAM_RANGE_CHECK_EN
  logic        range_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ref_words[int];
  logic [31:0] model_rdata = '0;
  logic [15:0] mem [0:63];

  sram_controller dut (
    .clock       (clock),
    .reset       (reset),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
`ifdef SRAM_RANGE_CHECK_EN
    .sram_oe_n   (sram_oe_n),
    .range_err   (range_err)
`else
    .sram_oe_n   (sram_oe_n)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural SRAM: drives data while oe_n is low, stores while we_n is low.
  assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[5:0]];

  always @(posedge clock) begin
    if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr[5:0]] <= sram_dq_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One load/store. abort_at >= 0 pulls reset low in that cycle index
  // (0 = IDLE cycle, 1..3 = LOW, 4..6 = HIGH).
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int abort_at);
    int          n;
    int          word;
    logic [17:0] lo;
    logic [31:0] exp;
    logic [31:0] got;
    word = int'(((addr - 32'd1024) >> 2) & 32'h1FFFF);
    lo   = {word[16:0], 1'b0};
    if (wr) begin
      exp = model_rdata;
      if (abort_at < 0) ref_words[word] = wd;
    end else begin
      exp = ref_words.exists(word) ? ref_words[word] : 32'h0;
      model_rdata = exp;
    end
    exp_q.push_back(exp);

    @(negedge clock);
    rd_en = rd; wr_en = wr; address = addr; write_data = wd;
    n = 0;
    while (1) begin
      #2;
      if (ready) break;
      if (n >= 1 && n <= 3) begin
        check($sformatf("lo_addr[%0d]", n), 32'(sram_addr), 32'(lo));
        if (wr) begin
          check($sformatf("lo_dq[%0d]", n), 32'(sram_dq_out), 32'(wd[15:0]));
          check($sformatf("lo_we_n[%0d]", n), 32'(sram_we_n), 32'd0);
          check($sformatf("lo_dq_oe[%0d]", n), 32'(sram_dq_oe), 32'd1);
          check($sformatf("lo_oe_n[%0d]", n), 32'(sram_oe_n), 32'd1);
        end else begin
          check($sformatf("lo_rd_oe_n[%0d]", n), 32'(sram_oe_n), 32'd0);
          check($sformatf("lo_rd_we_n[%0d]", n), 32'(sram_we_n), 32'd1);
          check($sformatf("lo_rd_dq_oe[%0d]", n), 32'(sram_dq_oe), 32'd0);
        end
      end
      if (n >= 4 && n <= 6) begin
        check($sformatf("hi_addr[%0d]", n), 32'(sram_addr), 32'(lo | 18'd1));
        if (wr) begin
          check($sformatf("hi_dq[%0d]", n), 32'(sram_dq_out), 32'(wd[31:16]));
          check($sformatf("hi_dq_oe[%0d]", n), 32'(sram_dq_oe), 32'd1);
          if (n >= 5) check($sformatf("hi_we_n[%0d]", n), 32'(sram_we_n), 32'd0);
        end else begin
          check($sformatf("hi_rd_oe_n[%0d]", n), 32'(sram_oe_n), 32'd0);
          check($sformatf("hi_rd_we_n[%0d]", n), 32'(sram_we_n), 32'd1);
        end
      end
      if (n == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_oe_n", 32'(sram_oe_n), 32'd1);
        check("abort_ready", 32'(ready), 32'd1);
        void'(exp_q.pop_back());
        model_rdata = '0;
        @(negedge clock);
        reset = 1'b1;
        return;
      end
      if (n >= 20) begin
        check("latency_timeout", 32'(n), 32'd7);
        break;
      end
      @(negedge clock);
      n++;
      if (n == 1) begin
        // Inputs changing mid-operation must not disturb the access.
        rd_en = 1'b0; wr_en = 1'b0; address = 32'hFFFF_FFF0; write_data = '0;
      end
    end
    got = exp_q.pop_front();
    check("freeze_cycles", 32'(n), 32'd7);
    check("done_read_data", read_data, got);
    check("done_we_n", 32'(sram_we_n), 32'd1);
    check("done_oe_n", 32'(sram_oe_n), 32'd1);
    check("done_dq_oe", 32'(sram_dq_oe), 32'd0);
    @(negedge clock);
    #2;
    check("idle_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    #2;
    check("idle_ready0", 32'(ready), 32'd1);
    check("idle_we_n0", 32'(sram_we_n), 32'd1);
    check("idle_oe_n0", 32'(sram_oe_n), 32'd1);
    check("idle_read_data0", read_data, 32'd0);

    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, -1);
    check("mem0", 32'(mem[0]), 32'h0000BEEF);
    check("mem1", 32'(mem[1]), 32'h0000DEAD);
    access(1'b1, 1'b0, 32'd1024, 32'h0, -1);
    access(1'b1, 1'b1, 32'd1028, 32'h12345678, -1);
    check("mem2", 32'(mem[2]), 32'h00005678);
    check("mem3", 32'(mem[3]), 32'h00001234);
    access(1'b1, 1'b0, 32'd1028, 32'h0, -1);

`ifdef SRAM_RANGE_CHECK_EN
    begin
      int n;
      @(negedge clock);
      rd_en = 1'b1; address = 32'd16;
      n = 0;
      while (1) begin
        #2;
        check("rc_oe_n", 32'(sram_oe_n), 32'd1);
        check("rc_we_n", 32'(sram_we_n), 32'd1);
        if (ready) break;
        if (n >= 20) break;
        @(negedge clock);
        n++;
        rd_en = 1'b0;
      end
      check("rc_freeze", 32'(n), 32'd1);
      check("rc_range_err", 32'(range_err), 32'd1);
      check("rc_read_data", read_data, 32'd0);
      model_rdata = '0;
      @(negedge clock);
      #2;
      check("rc_err_clear", 32'(range_err), 32'd0);
    end
`else
    // 1024 + 4*2^17 wraps back onto SRAM word 0.
    access(1'b1, 1'b0, 32'd525312, 32'h0, -1);
`endif

    access(1'b0, 1'b1, 32'd1032, 32'hAAAA5555, 4);
    #2;
    check("post_abort_ready", 32'(ready), 32'd1);
    check("post_abort_read_data", read_data, 32'd0);
    check("partial_low_kept", 32'(mem[4]), 32'h00005555);
    check("partial_high_unwritten", 32'(mem[5]), 32'h00000000);
    access(1'b1, 1'b0, 32'd1028, 32'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
